// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 command engine.
// Holds the state encoding, init ROM and bus bit positions.
package lcd_pkg;

  typedef enum logic [2:0] {
    PWRUP,
    INIT,
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    WAIT
  } lcd_state_e;

  localparam int unsigned INIT_LEN = 4;

  localparam logic [7:0] INIT_ROM [INIT_LEN] = '{
    8'h38,
    8'h0C,
    8'h01,
    8'h06
  };

  localparam int LCD_ON_BIT = 31;
  localparam int LCD_EN_BIT = 10;
  localparam int LCD_RS_BIT = 9;
  localparam int LCD_RW_BIT = 8;

  // Clear (0x01) and home (0x02/0x03) need the long busy time.
  function automatic logic is_long_cmd(
    input logic       rs,
    input logic [7:0] data
  );
    return !rs && (data[7:2] == 6'd0) && (data != 8'd0);
  endfunction

endpackage

// File: rtl/lcd_timer.sv
// Loadable down-counter for LCD phase timing.
// A load of N-1 makes the phase last exactly N cycles.
module lcd_timer #(
  parameter int unsigned     W       = 8,
  parameter logic [W-1:0]    RST_VAL = '0
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_count,
  output logic         o_done
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Load wins over counting; counting stops at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (i_load) begin
      cnt_d = i_load_val;
    end else if (i_count && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Counter register; reset preloads the power-up delay.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_done = (cnt_q == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780 command engine: power-up wait, init ROM, then
// handshaked byte commands turned into timed E/RS/DATA cycles.
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int unsigned SETUP_CYCLES      = 2,
  parameter int unsigned PULSE_CYCLES      = 12,
  parameter int unsigned HOLD_CYCLES       = 2,
  parameter int unsigned CMD_WAIT_CYCLES   = 2000,
  parameter int unsigned CLEAR_WAIT_CYCLES = 82000,
  parameter int unsigned POWERUP_CYCLES    = 750000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_cmd_vld,
  input  logic        i_cmd_rs,
  input  logic [7:0]  i_cmd_data,
  output logic        o_cmd_rdy,
  output logic        o_lcd_on,
  output logic        o_lcd_en,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic [7:0]  o_lcd_data,
  output logic [31:0] o_io_lcd
);

  localparam int unsigned M1 =
    (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
  localparam int unsigned M2 =
    (HOLD_CYCLES > CMD_WAIT_CYCLES) ? HOLD_CYCLES : CMD_WAIT_CYCLES;
  localparam int unsigned M3 =
    (CLEAR_WAIT_CYCLES > POWERUP_CYCLES) ?
    CLEAR_WAIT_CYCLES : POWERUP_CYCLES;
  localparam int unsigned M12 = (M1 > M2) ? M1 : M2;
  localparam int unsigned MAXV = (M12 > M3) ? M12 : M3;
  localparam int unsigned TW = $clog2(MAXV) + 1;

  typedef logic [TW-1:0] cnt_t;

  localparam cnt_t SETUP_LD = cnt_t'(SETUP_CYCLES - 1);
  localparam cnt_t PULSE_LD = cnt_t'(PULSE_CYCLES - 1);
  localparam cnt_t HOLD_LD  = cnt_t'(HOLD_CYCLES - 1);
  localparam cnt_t CMD_LD   = cnt_t'(CMD_WAIT_CYCLES - 1);
  localparam cnt_t CLR_LD   = cnt_t'(CLEAR_WAIT_CYCLES - 1);
  localparam cnt_t PWR_LD   = cnt_t'(POWERUP_CYCLES - 1);

  lcd_state_e  state_q, state_d;
  logic        rs_q, rs_d;
  logic [7:0]  data_q, data_d;
  logic [2:0]  idx_q, idx_d;
  logic        en_q, en_d;
  logic        rdy_q, rdy_d;
  logic        on_q, on_d;
  logic [31:0] io_q, io_d;

  logic        tmr_load;
  cnt_t        tmr_val;
  logic        tmr_count;
  logic        tmr_done;

  lcd_timer #(
    .W       (TW),
    .RST_VAL (PWR_LD)
  ) u_timer (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (tmr_load),
    .i_load_val (tmr_val),
    .i_count    (tmr_count),
    .o_done     (tmr_done)
  );

  // Next state, bus latch, init index and timer control.
  always_comb begin
    state_d   = state_q;
    rs_d      = rs_q;
    data_d    = data_q;
    idx_d     = idx_q;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    tmr_count = 1'b0;
    unique case (state_q)
      PWRUP: begin
        tmr_count = 1'b1;
        if (tmr_done) begin
          state_d = INIT;
        end
      end
      INIT: begin
        rs_d     = 1'b0;
        data_d   = INIT_ROM[idx_q[1:0]];
        idx_d    = idx_q + 3'd1;
        state_d  = SETUP;
        tmr_load = 1'b1;
        tmr_val  = SETUP_LD;
      end
      IDLE: begin
        if (i_cmd_vld) begin
          rs_d     = i_cmd_rs;
          data_d   = i_cmd_data;
          state_d  = SETUP;
          tmr_load = 1'b1;
          tmr_val  = SETUP_LD;
        end
      end
      SETUP: begin
        tmr_count = 1'b1;
        if (tmr_done) begin
          state_d  = PULSE;
          tmr_load = 1'b1;
          tmr_val  = PULSE_LD;
        end
      end
      PULSE: begin
        tmr_count = 1'b1;
        if (tmr_done) begin
          state_d  = HOLD;
          tmr_load = 1'b1;
          tmr_val  = HOLD_LD;
        end
      end
      HOLD: begin
        tmr_count = 1'b1;
        if (tmr_done) begin
          state_d  = WAIT;
          tmr_load = 1'b1;
          tmr_val  = is_long_cmd(rs_q, data_q) ? CLR_LD : CMD_LD;
        end
      end
      WAIT: begin
        tmr_count = 1'b1;
        if (tmr_done) begin
          state_d = (idx_q == 3'(INIT_LEN)) ? IDLE : INIT;
        end
      end
      default: begin
        state_d = PWRUP;
      end
    endcase
  end

  // Registered bus image derived from the next state.
  always_comb begin
    en_d  = (state_d == PULSE);
    rdy_d = (state_d == IDLE);
    on_d  = 1'b1;
    io_d  = '0;
    io_d[LCD_ON_BIT] = on_d;
    io_d[LCD_EN_BIT] = en_d;
    io_d[LCD_RS_BIT] = rs_d;
    io_d[LCD_RW_BIT] = 1'b0;
    io_d[7:0]        = data_d;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= PWRUP;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
      idx_q   <= 3'd0;
      en_q    <= 1'b0;
      rdy_q   <= 1'b0;
      on_q    <= 1'b0;
      io_q    <= 32'h0;
    end else begin
      state_q <= state_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      en_q    <= en_d;
      rdy_q   <= rdy_d;
      on_q    <= on_d;
      io_q    <= io_d;
    end
  end

  assign o_cmd_rdy  = rdy_q;
  assign o_lcd_on   = on_q;
  assign o_lcd_en   = en_q;
  assign o_lcd_rs   = rs_q;
  assign o_lcd_rw   = 1'b0;
  assign o_lcd_data = data_q;
  assign o_io_lcd   = io_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Directed bench for lcd_ctrl with short timing parameters.
// Samples on the falling edge; drives inputs there too.
module tb_lcd_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        vld;
  logic        rs;
  logic [7:0]  din;
  logic        o_cmd_rdy;
  logic        o_lcd_on;
  logic        o_lcd_en;
  logic        o_lcd_rs;
  logic        o_lcd_rw;
  logic [7:0]  o_lcd_data;
  logic [31:0] o_io_lcd;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  lcd_ctrl #(
    .SETUP_CYCLES      (2),
    .PULSE_CYCLES      (3),
    .HOLD_CYCLES       (1),
    .CMD_WAIT_CYCLES   (4),
    .CLEAR_WAIT_CYCLES (10),
    .POWERUP_CYCLES    (20)
  ) dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_cmd_vld  (vld),
    .i_cmd_rs   (rs),
    .i_cmd_data (din),
    .o_cmd_rdy  (o_cmd_rdy),
    .o_lcd_on   (o_lcd_on),
    .o_lcd_en   (o_lcd_en),
    .o_lcd_rs   (o_lcd_rs),
    .o_lcd_rw   (o_lcd_rw),
    .o_lcd_data (o_lcd_data),
    .o_io_lcd   (o_io_lcd)
  );

  // Caller has just released reset at this falling edge (cycle 0).
  // Pulses expected at cycles 23, 34, 45, 62; ready at cycle 70.
  task automatic run_init(input string tag, input bit tog);
    int         ek [4] = '{23, 34, 45, 62};
    logic [7:0] ed [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};
    int         rk [4] = '{-1, -1, -1, -1};
    logic [7:0] rd [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
    int         w  [4] = '{0, 0, 0, 0};
    int         nrise = 0;
    int         first_rdy = -1;
    logic       pen = 1'b0;
    for (int k = 0; k < 80; k++) begin
      if (k == 0) begin
        tests++;
        if (o_lcd_on !== 1'b0) begin
          fails++;
          $display("FAIL %s on_c0 got=%b exp=0", tag, o_lcd_on);
        end
      end
      if (k == 1) begin
        tests++;
        if (o_lcd_on !== 1'b1) begin
          fails++;
          $display("FAIL %s on_c1 got=%b exp=1", tag, o_lcd_on);
        end
      end
      if (o_lcd_en && !pen) begin
        if (nrise < 4) begin
          rk[nrise] = k;
          rd[nrise] = o_lcd_data;
        end
        nrise++;
      end
      if (o_lcd_en && nrise >= 1 && nrise <= 4) w[nrise-1]++;
      if (o_cmd_rdy && first_rdy < 0) first_rdy = k;
      pen = o_lcd_en;
      vld = tog && (k < 68) && (k % 2 == 1);
      rs  = 1'b1;
      din = 8'hAA;
      @(negedge clk);
    end
    vld = 1'b0;
    din = 8'h00;
    rs  = 1'b0;
    tests++;
    if (nrise !== 4) begin
      fails++;
      $display("FAIL %s pulse_count got=%0d exp=4", tag, nrise);
    end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (rk[i] !== ek[i]) begin
        fails++;
        $display("FAIL %s rise%0d got=%0d exp=%0d", tag, i, rk[i], ek[i]);
      end
      tests++;
      if (rd[i] !== ed[i]) begin
        fails++;
        $display("FAIL %s data%0d got=%h exp=%h", tag, i, rd[i], ed[i]);
      end
      tests++;
      if (w[i] !== 3) begin
        fails++;
        $display("FAIL %s width%0d got=%0d exp=3", tag, i, w[i]);
      end
    end
    tests++;
    if (first_rdy !== 70) begin
      fails++;
      $display("FAIL %s rdy_cycle got=%0d exp=70", tag, first_rdy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    vld = 1'b0;
    rs  = 1'b0;
    din = 8'h00;
    repeat (3) @(negedge clk);
    tests++;
    if ({o_cmd_rdy, o_lcd_on, o_lcd_en, o_lcd_rs, o_lcd_rw} !== 5'b0 ||
        o_lcd_data !== 8'h00 || o_io_lcd !== 32'h0) begin
      fails++;
      $display("FAIL reset_vals rdy=%b on=%b en=%b rs=%b rw=%b d=%h io=%h exp all 0",
               o_cmd_rdy, o_lcd_on, o_lcd_en, o_lcd_rs, o_lcd_rw,
               o_lcd_data, o_io_lcd);
    end
    rst = 1'b0;
    run_init("init", 1'b0);
  endtask

  task automatic test_single();
    logic        exp_en;
    logic        exp_rdy;
    logic [31:0] exp_io;
    vld = 1'b1;
    rs  = 1'b1;
    din = 8'h41;
    @(negedge clk);
    vld = 1'b0;
    rs  = 1'b0;
    din = 8'h00;
    for (int j = 0; j <= 12; j++) begin
      exp_en  = (j >= 2) && (j <= 4);
      exp_rdy = (j >= 10);
      exp_io  = exp_en ? 32'h8000_0641 : 32'h8000_0241;
      tests++;
      if (o_lcd_en !== exp_en) begin
        fails++;
        $display("FAIL single_en j=%0d got=%b exp=%b", j, o_lcd_en, exp_en);
      end
      tests++;
      if (o_cmd_rdy !== exp_rdy) begin
        fails++;
        $display("FAIL single_rdy j=%0d got=%b exp=%b", j, o_cmd_rdy, exp_rdy);
      end
      tests++;
      if (o_io_lcd !== exp_io) begin
        fails++;
        $display("FAIL single_io j=%0d got=%h exp=%h", j, o_io_lcd, exp_io);
      end
      @(negedge clk);
    end
    tests++;
    if (o_lcd_rw !== 1'b0) begin
      fails++;
      $display("FAIL single_rw got=%b exp=0", o_lcd_rw);
    end
  endtask

  task automatic test_back_to_back();
    vld = 1'b1;
    rs  = 1'b1;
    din = 8'h48;
    @(negedge clk);
    din = 8'h49;
    for (int j = 0; j <= 10; j++) begin
      tests++;
      if (o_lcd_data !== 8'h48) begin
        fails++;
        $display("FAIL b2b_data0 j=%0d got=%h exp=48", j, o_lcd_data);
      end
      tests++;
      if (o_cmd_rdy !== (j == 10)) begin
        fails++;
        $display("FAIL b2b_rdy j=%0d got=%b exp=%b", j, o_cmd_rdy, j == 10);
      end
      @(negedge clk);
    end
    tests++;
    if (o_lcd_data !== 8'h49 || o_cmd_rdy !== 1'b0) begin
      fails++;
      $display("FAIL b2b_second d=%h rdy=%b exp d=49 rdy=0",
               o_lcd_data, o_cmd_rdy);
    end
    vld = 1'b0;
    din = 8'h00;
    repeat (11) @(negedge clk);
    tests++;
    if (o_cmd_rdy !== 1'b1) begin
      fails++;
      $display("FAIL b2b_idle got=%b exp=1", o_cmd_rdy);
    end
  endtask

  task automatic test_long_wait();
    vld = 1'b1;
    rs  = 1'b0;
    din = 8'h01;
    @(negedge clk);
    vld = 1'b0;
    for (int j = 0; j <= 18; j++) begin
      tests++;
      if (o_cmd_rdy !== (j >= 16)) begin
        fails++;
        $display("FAIL clr_rdy j=%0d got=%b exp=%b", j, o_cmd_rdy, j >= 16);
      end
      tests++;
      if (o_lcd_en !== (j >= 2 && j <= 4)) begin
        fails++;
        $display("FAIL clr_en j=%0d got=%b exp=%b", j, o_lcd_en,
                 j >= 2 && j <= 4);
      end
      tests++;
      if (o_lcd_data !== 8'h01 || o_lcd_rs !== 1'b0) begin
        fails++;
        $display("FAIL clr_latch j=%0d d=%h rs=%b exp d=01 rs=0",
                 j, o_lcd_data, o_lcd_rs);
      end
      vld = (j >= 1) && (j <= 14) && (j % 2 == 1);
      rs  = 1'b1;
      din = 8'h55;
      @(negedge clk);
    end
    vld = 1'b1;
    rs  = 1'b0;
    din = 8'h80;
    @(negedge clk);
    vld = 1'b0;
    din = 8'h00;
    for (int j = 0; j <= 10; j++) begin
      tests++;
      if (o_cmd_rdy !== (j >= 10)) begin
        fails++;
        $display("FAIL ddram_rdy j=%0d got=%b exp=%b", j, o_cmd_rdy, j >= 10);
      end
      tests++;
      if (o_lcd_data !== 8'h80 || o_lcd_rs !== 1'b0) begin
        fails++;
        $display("FAIL ddram_latch j=%0d d=%h rs=%b exp d=80 rs=0",
                 j, o_lcd_data, o_lcd_rs);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    vld = 1'b1;
    rs  = 1'b1;
    din = 8'h41;
    @(negedge clk);
    vld = 1'b0;
    din = 8'h00;
    repeat (3) @(negedge clk);
    tests++;
    if (o_lcd_en !== 1'b1) begin
      fails++;
      $display("FAIL mid_pre_en got=%b exp=1", o_lcd_en);
    end
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if (o_lcd_en !== 1'b0 || o_cmd_rdy !== 1'b0 ||
        o_io_lcd !== 32'h0 || o_lcd_on !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset en=%b rdy=%b io=%h on=%b exp 0 0 0 0",
               o_lcd_en, o_cmd_rdy, o_io_lcd, o_lcd_on);
    end
    rst = 1'b0;
    run_init("replay", 1'b1);
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_long_wait();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
